interconnection_arbiter: RTL and testbench
==========================================

# interconnection_arbiter

Round-robin arbiter between NUM_CORES core request ports and the single interconnection port of `frontend_scheduler`. It grants one core at a time and stamps the granted index into the command's `core_num` field. Write requests hold the grant until the burst completes; read requests are single transfers. Read-return data from the scheduler is routed back to the owning core by `core_num`.

## Interface
- NUM_CORES, 4, number of core request ports (≥2); grant index width is `$clog2(NUM_CORES)` and fits in `core_num_t`.
- WRITE_BEATS, 4, 256-bit beats per write request (backend word / frontend word).
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_core_request_valid  in  NUM_CORES  per-core request/beat valid.
- i_core_request  in  NUM_CORES × frontend_command_t  per-core command; field `op_type` selects OP_READ/OP_WRITE.
- i_core_write_data  in  NUM_CORES × 256  per-core write beat.
- o_core_request_ready  out  NUM_CORES  per-core beat accepted.
- i_scheduler_ready  in  1  scheduler can accept a transfer.
- o_interconnection_request_valid  out  1  transfer valid toward scheduler.
- o_interconnection_request  out  frontend_command_t  granted command with `core_num` overwritten by grant index.
- o_interconnection_write_data  out  256  granted core's write beat.
- o_interconnection_write_data_last  out  1  final write beat.
- o_interconnection_ready  out  1  ready toward scheduler return path.
- i_scheduler_request_valid, i_scheduler_read_data[255:0], i_scheduler_read_data_last, i_scheduler_request_id (req_id_t), i_scheduler_core_num (core_num_t)  in  scheduler read return.
- o_core_read_valid  out  NUM_CORES  one-hot return valid.
- o_core_read_data / o_core_read_last / o_core_read_id  out  256 / 1 / req_id_t  return payload, broadcast to all cores.
- i_core_read_ready  in  NUM_CORES  per-core return ready.
- o_bad_core_num  out  1  sticky: a return carried core_num ≥ NUM_CORES.

## Operation
- FSM states: IDLE, SEND.
- IDLE: if any `i_core_request_valid`, pick the first valid index searching upward from `last_grant+1` modulo NUM_CORES. Register it as `grant`, clear `beat_cnt`, go to SEND. All request-side outputs are 0 in IDLE.
- SEND: outputs are muxed combinationally from core `grant`.
  - o_interconnection_request_valid = i_core_request_valid[grant].
  - o_core_request_ready[grant] = i_scheduler_ready; all other core readies are 0.
  - A transfer occurs when valid & ready are both high.
- Read (`op_type`=OP_READ): exactly one transfer, with last=0. On that transfer: `last_grant`←`grant`, go to IDLE.
- Write: WRITE_BEATS transfers, with the command held by the core and re-presented on every beat.
  - `beat_cnt` increments on each transfer.
  - last = (beat_cnt == WRITE_BEATS-1).
  - On the last transfer: `last_grant`←`grant`, go to IDLE.
- `op_type` is sampled from the granted core at the first transfer; the core must keep it stable for the whole burst.
- If the granted core deasserts valid mid-burst: output valid drops, `beat_cnt` holds, and the grant stays locked. Other cores are never granted mid-burst.
- Return path (combinational):
  - o_core_read_valid[i] = i_scheduler_request_valid & (i_scheduler_core_num == i).
  - o_interconnection_ready = i_core_read_ready[i_scheduler_core_num].
- Out-of-range core_num: o_interconnection_ready = 1, so the return is drained. No core valid is asserted. o_bad_core_num is set and stays set until reset.
- Request and return paths are independent and operate simultaneously.

## Timing
- Reset values: FSM=IDLE, `last_grant`=NUM_CORES-1 (core 0 has first priority), `beat_cnt`=0, o_bad_core_num=0. All request-side valid/ready/last outputs are 0.
- Arbitration latency: core valid sampled in IDLE at edge N → output valid in cycle N+1.
- One idle (arbitration) cycle between consecutive requests. Maximum throughput is one read per 2 cycles, or WRITE_BEATS beats per WRITE_BEATS+1 cycles.
- Return path has zero latency (combinational) and no internal buffering.
- Reset asserted mid-burst: the burst is abandoned immediately and the FSM returns to IDLE. The scheduler shares the reset.
- Fairness: the core granted last has the lowest priority next time. A continuously valid core waits at most NUM_CORES-1 requests.

## Test plan
- Core 1 read only, scheduler ready=1 → valid in cycle after request; command `core_num`=1, last=0; core 1 ready for exactly 1 cycle; FSM back in IDLE.
- Core 2 write, 4 beats D0..D3, ready=1 → 4 consecutive transfers carrying D0..D3; last only on D3; `core_num`=2; next grant after 1 idle cycle.
- All 4 cores valid continuously, reads → grant order 0,1,2,3,0,…; each core granted once per 8 cycles.
- Write burst with ready low on beat 2 for 3 cycles, plus core 0 requesting meanwhile → beat 2 held and not duplicated; core 0 is not granted until beat 3 completes; last appears exactly once.
- Return core_num=3 with i_core_read_ready[3]=0 for 2 cycles → o_core_read_valid=4'b1000 is held and o_interconnection_ready=0 until ready rises. Return with core_num=5 (NUM_CORES=4) → drained and o_bad_core_num=1.
- Assert i_rst_n=0 after beat 1 of a write → outputs 0 immediately. After release, core 0 has priority and `beat_cnt`=0.

Source files
------------

// File: rtl/interconnection_arbiter.sv
// Round-robin arbiter: NUM_CORES core request ports onto one scheduler port,
// write bursts hold the grant; read returns are routed back by core_num.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_core_request_valid/_request        per-core command + valid
//   i_core_write_data                    per-core 256-bit write beat
//   o_core_request_ready                 per-core beat accepted
//   i_scheduler_ready                    scheduler accepts a transfer
//   o_interconnection_request_valid/...  granted command, data, last
//   o_interconnection_ready              ready toward scheduler return
//   i_scheduler_request_valid/...        scheduler read return
//   o_core_read_valid/_data/_last/_id    return, valid one-hot per core
//   i_core_read_ready                    per-core return ready
//   o_bad_core_num                       sticky out-of-range return flag

package arbiter_pkg;
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_type_t;

    typedef logic [3:0] core_num_t;
    typedef logic [7:0] req_id_t;

    typedef struct packed {
        op_type_t    op_type;
        core_num_t   core_num;
        req_id_t     req_id;
        logic [31:0] addr;
    } frontend_command_t;
endpackage

module interconnection_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int WRITE_BEATS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic [NUM_CORES-1:0]  i_core_request_valid,
    input  frontend_command_t     i_core_request [NUM_CORES],
    input  logic [255:0]          i_core_write_data [NUM_CORES],
    output logic [NUM_CORES-1:0]  o_core_request_ready,

    input  logic                  i_scheduler_ready,
    output logic                  o_interconnection_request_valid,
    output frontend_command_t     o_interconnection_request,
    output logic [255:0]          o_interconnection_write_data,
    output logic                  o_interconnection_write_data_last,
    output logic                  o_interconnection_ready,

    input  logic                  i_scheduler_request_valid,
    input  logic [255:0]          i_scheduler_read_data,
    input  logic                  i_scheduler_read_data_last,
    input  req_id_t               i_scheduler_request_id,
    input  core_num_t             i_scheduler_core_num,

    output logic [NUM_CORES-1:0]  o_core_read_valid,
    output logic [255:0]          o_core_read_data,
    output logic                  o_core_read_last,
    output req_id_t               o_core_read_id,
    input  logic [NUM_CORES-1:0]  i_core_read_ready,

    output logic                  o_bad_core_num
);

    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int BW = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            bad_q, bad_d;

    logic [GW-1:0]   pick;
    logic            any_valid;
    logic            is_write;
    logic            last_beat;
    logic            xfer;

    // Walk from farthest to nearest so the core closest after
    // last_grant overwrites the others and wins.
    always_comb begin
        pick      = last_grant_q;
        any_valid = 1'b0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            if (i_core_request_valid[(int'(last_grant_q) + k) % NUM_CORES]) begin
                pick      = GW'((int'(last_grant_q) + k) % NUM_CORES);
                any_valid = 1'b1;
            end
        end
    end

    assign is_write  = (i_core_request[grant_q].op_type == OP_WRITE);
    assign last_beat = (beat_cnt_q == BW'(WRITE_BEATS - 1));
    assign xfer      = (state_q == SEND) && i_core_request_valid[grant_q]
                       && i_scheduler_ready;

    // Request-side outputs and FSM next state
    always_comb begin
        o_core_request_ready              = '0;
        o_interconnection_request_valid   = 1'b0;
        o_interconnection_request         = '0;
        o_interconnection_write_data      = '0;
        o_interconnection_write_data_last = 1'b0;

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                o_interconnection_request_valid = i_core_request_valid[grant_q];
                o_core_request_ready[grant_q]   = i_scheduler_ready;
                o_interconnection_request       = i_core_request[grant_q];
                o_interconnection_request.core_num = core_num_t'(grant_q);
                o_interconnection_write_data    = i_core_write_data[grant_q];
                o_interconnection_write_data_last = is_write && last_beat;
                if (xfer) begin
                    if (!is_write || last_beat) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return path: purely combinational, payload broadcast to all cores.
    // An out-of-range core_num is drained (ready=1) with no core valid.
    always_comb begin
        o_core_read_valid       = '0;
        o_interconnection_ready = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (i_scheduler_core_num == core_num_t'(i)) begin
                o_core_read_valid[i]    = i_scheduler_request_valid;
                o_interconnection_ready = i_core_read_ready[i];
            end
        end
        bad_d = bad_q | (i_scheduler_request_valid
                         && (int'(i_scheduler_core_num) >= NUM_CORES));
    end

    assign o_core_read_data = i_scheduler_read_data;
    assign o_core_read_last = i_scheduler_read_data_last;
    assign o_core_read_id   = i_scheduler_request_id;
    assign o_bad_core_num   = bad_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CORES - 1);
            beat_cnt_q   <= '0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            bad_q        <= bad_d;
        end
    end

endmodule

// File: tb/tb_interconnection_arbiter.sv
// Testbench for interconnection_arbiter: directed scenarios plus random
// traffic checked every cycle against a behavioural arbitration model.
module tb_interconnection_arbiter;
    import arbiter_pkg::*;

    localparam int N  = 4;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      cv;
    frontend_command_t creq [N];
    logic [255:0]      cwd [N];
    logic [N-1:0]      c_rdy;
    logic              sr;
    logic              ivalid;
    frontend_command_t icmd;
    logic [255:0]      iwd;
    logic              ilast;
    logic              irdy;
    logic              sv;
    logic [255:0]      sdata;
    logic              slast;
    req_id_t           sid;
    core_num_t         scn;
    logic [N-1:0]      crv;
    logic [255:0]      crd;
    logic              crl;
    req_id_t           cri;
    logic [N-1:0]      crr;
    logic              bad;

    interconnection_arbiter #(.NUM_CORES(N), .WRITE_BEATS(WB)) dut (
        .i_clk                             (clk),
        .i_rst_n                           (rst_n),
        .i_core_request_valid              (cv),
        .i_core_request                    (creq),
        .i_core_write_data                 (cwd),
        .o_core_request_ready              (c_rdy),
        .i_scheduler_ready                 (sr),
        .o_interconnection_request_valid   (ivalid),
        .o_interconnection_request         (icmd),
        .o_interconnection_write_data      (iwd),
        .o_interconnection_write_data_last (ilast),
        .o_interconnection_ready           (irdy),
        .i_scheduler_request_valid         (sv),
        .i_scheduler_read_data             (sdata),
        .i_scheduler_read_data_last        (slast),
        .i_scheduler_request_id            (sid),
        .i_scheduler_core_num              (scn),
        .o_core_read_valid                 (crv),
        .o_core_read_data                  (crd),
        .o_core_read_last                  (crl),
        .o_core_read_id                    (cri),
        .i_core_read_ready                 (crr),
        .o_bad_core_num                    (bad)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the port, beats done, who went last.
    bit           m_busy;
    int           m_owner;
    int           m_lastg;
    int           m_beat;
    bit           m_bad;
    logic [N-1:0] acc;

    // Random core drivers
    bit c_act [N];
    int c_left [N];

    logic [255:0] dtab [4];

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Inputs are already set (just after negedge); check, then clock.
    task automatic cycle();
        logic [N-1:0]      e_rdy;
        logic [N-1:0]      e_crv;
        logic              e_valid;
        logic              e_last;
        logic              e_irdy;
        frontend_command_t e_cmd;
        logic [255:0]      e_wd;
        int                pk;
        if (!rst_n) begin
            m_busy = 0; m_lastg = N - 1; m_beat = 0; m_bad = 0;
        end
        e_rdy = '0; e_valid = 0; e_last = 0; e_cmd = '0; e_wd = '0;
        if (m_busy) begin
            e_valid = cv[m_owner];
            e_rdy[m_owner] = sr;
            e_cmd = creq[m_owner];
            e_cmd.core_num = core_num_t'(m_owner);
            e_wd = cwd[m_owner];
            e_last = (creq[m_owner].op_type == OP_WRITE) && (m_beat == WB - 1);
        end
        e_crv = '0;
        e_irdy = 1'b1;
        if (int'(scn) < N) begin
            e_crv[scn[1:0]] = sv;
            e_irdy = crr[scn[1:0]];
        end
        #1;
        check("req_valid", ivalid, e_valid);
        check("core_ready", c_rdy, e_rdy);
        check("req_cmd", icmd, e_cmd);
        check("wr_data", iwd, e_wd);
        check("wr_last", ilast, e_last);
        check("rd_valid", crv, e_crv);
        check("ic_ready", irdy, e_irdy);
        check("rd_payload", {crd, crl, cri}, {sdata, slast, sid});
        check("bad_core", bad, m_bad);
        acc = cv & e_rdy;
        @(posedge clk);
        if (rst_n) begin
            if (sv && int'(scn) >= N) m_bad = 1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    pk = (m_lastg + k) % N;
                    if (cv[pk]) begin
                        m_busy = 1; m_owner = pk; m_beat = 0;
                        break;
                    end
                end
            end else if (cv[m_owner] && sr) begin
                if (creq[m_owner].op_type == OP_READ || m_beat == WB - 1) begin
                    m_busy = 0;
                    m_lastg = m_owner;
                end else begin
                    m_beat++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (acc[i] && c_act[i]) begin
                c_left[i]--;
                cwd[i] = rand256();
                if (c_left[i] == 0) c_act[i] = 0;
            end
            if (!c_act[i] && $urandom_range(0, 2) == 0) begin
                c_act[i] = 1;
                creq[i].op_type  = op_type_t'($urandom_range(0, 1));
                creq[i].core_num = core_num_t'($urandom_range(0, 15));
                creq[i].req_id   = req_id_t'($urandom);
                creq[i].addr     = $urandom;
                c_left[i] = (creq[i].op_type == OP_READ) ? 1 : WB;
                cwd[i] = rand256();
            end
            cv[i] = c_act[i] && ($urandom_range(0, 4) != 0);
        end
        sr    = ($urandom_range(0, 3) != 0);
        sv    = $urandom_range(0, 1) == 1;
        scn   = ($urandom_range(0, 9) == 0) ? core_num_t'($urandom_range(4, 5))
                                            : core_num_t'($urandom_range(0, 3));
        crr   = N'($urandom);
        sdata = rand256();
        slast = $urandom_range(0, 1) == 1;
        sid   = req_id_t'($urandom);
    endtask

    initial begin
        int b;
        int lastcnt;
        int srt [7];
        srt = '{1, 1, 0, 0, 0, 1, 1};
        for (int j = 0; j < 4; j++) dtab[j] = {64'hD0D0 + 64'(j), 192'(j + 1)};
        cv = '0; sr = 0; sv = 0; sdata = '0; slast = 0; sid = '0;
        scn = '0; crr = '0; acc = '0;
        for (int i = 0; i < N; i++) begin
            creq[i] = '0; cwd[i] = '0; c_act[i] = 0; c_left[i] = 0;
        end
        m_busy = 0; m_lastg = N - 1; m_beat = 0; m_bad = 0; m_owner = 0;
        @(negedge clk);

        // Reset state
        cycle();
        cycle();
        rst_n = 1'b1;

        // Core 1 single read
        creq[1] = '{OP_READ, 4'd7, 8'h11, 32'h1000};
        cwd[1] = rand256();
        cv = 4'b0010; sr = 1;
        cycle();
        #1;
        check("t1_core_num", icmd.core_num, 1);
        check("t1_valid", ivalid, 1);
        check("t1_last", ilast, 0);
        cycle();
        cv = '0;
        cycle();

        // Core 2 write burst D0..D3
        creq[2] = '{OP_WRITE, 4'd0, 8'h22, 32'h2000};
        cwd[2] = dtab[0];
        cv = 4'b0100;
        cycle();
        for (int k = 0; k < WB; k++) begin
            cwd[2] = dtab[k];
            #1;
            check("t2_data", iwd, dtab[k]);
            check("t2_last", ilast, k == WB - 1);
            check("t2_core_num", icmd.core_num, 2);
            cycle();
        end
        cv = '0;
        cycle();

        // All cores reading continuously: rotation after core 2
        for (int i = 0; i < N; i++) creq[i] = '{OP_READ, 4'd9, 8'(i), 32'(i)};
        cv = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            #1;
            check("t3_grant", icmd.core_num, (3 + k) % N);
            cycle();
        end
        cv = '0;
        cycle();

        // Write burst on core 1 with scheduler stall, core 0 waiting
        creq[1] = '{OP_WRITE, 4'd0, 8'h33, 32'h3000};
        cwd[1] = dtab[0];
        cv = 4'b0010;
        cycle();
        cv = 4'b0011;
        b = 0;
        lastcnt = 0;
        for (int s = 0; s < 7; s++) begin
            sr = srt[s][0];
            cwd[1] = dtab[b];
            #1;
            check("t4_owner", icmd.core_num, 1);
            check("t4_data", iwd, dtab[b]);
            if (ilast && sr) lastcnt++;
            cycle();
            if (sr) b++;
        end
        check("t4_last_once", lastcnt, 1);
        cv = 4'b0001;
        cycle();
        #1;
        check("t4_next", icmd.core_num, 0);
        cycle();
        cv = '0;

        // Return path: stalled core 3, then out-of-range core_num
        sv = 1; scn = 4'd3; crr = 4'b0000; sdata = rand256(); sid = 8'h5A;
        #1;
        check("t5_crv", crv, 4'b1000);
        check("t5_irdy", irdy, 0);
        cycle();
        cycle();
        crr = 4'b1000;
        cycle();
        scn = 4'd5; crr = 4'b0000;
        #1;
        check("t5_drain", irdy, 1);
        check("t5_crv_none", crv, 0);
        cycle();
        sv = 0;
        #1;
        check("t5_bad", bad, 1);
        cycle();

        // Reset in the middle of a write burst
        creq[2] = '{OP_WRITE, 4'd0, 8'h44, 32'h4000};
        cv = 4'b0100;
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("t6_valid", ivalid, 0);
        check("t6_ready", c_rdy, 0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) creq[i] = '{OP_READ, 4'd0, 8'h60, 32'h0};
        cv = 4'b1101;
        cycle();
        #1;
        check("t6_first", icmd.core_num, 0);
        check("t6_bad_clr", bad, 0);
        cycle();
        cv = '0;
        cycle();

        // Random traffic
        acc = '0;
        for (int i = 0; i < N; i++) c_act[i] = 0;
        for (int t = 0; t < 600; t++) begin
            drive_random();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
